// File: rtl/n1_sarb_pkg.sv
// Shared types for the stack bus arbiter: FSM encoding, owner flag and the
// response bundle with its routing helper.
package n1_sarb_pkg;

  localparam int SARB_DAT_W = 16;

  typedef enum logic [1:0] {
    SARB_IDLE    = 2'b00,
    SARB_GNT_IPS = 2'b01,
    SARB_GNT_IRS = 2'b10
  } sarb_state_t;

  typedef enum logic {
    OWNER_IPS = 1'b0,
    OWNER_IRS = 1'b1
  } sarb_owner_t;

  typedef struct packed {
    logic ack;
    logic err;
    logic rty;
  } sarb_rsp_t;

  // Responses pass to an initiator only while it owns the bus.
  function automatic sarb_rsp_t rsp_route(input sarb_rsp_t rsp, input logic sel);
    rsp_route = sel ? rsp : '0;
  endfunction

endpackage

// File: rtl/n1_sarb_if.sv
// Pipelined Wishbone stack-memory link, used both initiator-side and target-side.
interface n1_sarb_if #(
  parameter int SP_WIDTH = 12
);
  import n1_sarb_pkg::*;

  // Handshake: an access transfers on a clock edge where cyc & stb & ~stall;
  // each transferred access is later closed by exactly one of ack/err/rty,
  // with rdat valid alongside ack. Dropping cyc abandons all open accesses.
  logic                  cyc;
  logic                  stb;
  logic                  we;
  logic [SP_WIDTH-1:0]   adr;
  logic [SARB_DAT_W-1:0] wdat;
  logic                  ack;
  logic                  err;
  logic                  rty;
  logic                  stall;
  logic [SARB_DAT_W-1:0] rdat;

  modport master (
    output cyc, stb, we, adr, wdat,
    input  ack, err, rty, stall, rdat
  );

  modport slave (
    input  cyc, stb, we, adr, wdat,
    output ack, err, rty, stall, rdat
  );

endinterface

// File: rtl/n1_sarb.sv
// Stack bus arbiter: round-robin sharing of one stack-RAM Wishbone port between
// the parameter-stack (IPS) and return-stack (IRS) initiators.
module n1_sarb
  import n1_sarb_pkg::*;
#(
  parameter  int SP_WIDTH = 12,
  parameter  int MAX_OUT  = 2,
  localparam int CNT_W    = $clog2(MAX_OUT + 1)
) (
  input  logic             clk_i,
  input  logic             async_rst_i,
  n1_sarb_if.slave         ips_sarb,
  n1_sarb_if.slave         irs_sarb,
  n1_sarb_if.master        sarb,
  output logic [1:0]       prb_sarb_state_o,
  output logic [CNT_W-1:0] prb_sarb_cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  sarb_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  sarb_owner_t      last_q, last_d;

  sarb_rsp_t rsp, ips_rsp, irs_rsp;
  logic      rsp_any;
  logic      cap;
  logic      accept;

  assign rsp     = '{ack: sarb.ack, err: sarb.err, rty: sarb.rty};
  assign rsp_any = sarb.ack | sarb.err | sarb.rty;
  // A response in the same cycle frees a slot, so the cap only bites without one.
  assign cap     = (cnt_q == CNT_MAX) & ~rsp_any;
  assign accept  = sarb.stb & ~sarb.stall;

  // State register: FSM, outstanding counter and last-owner flag.
  always_ff @(posedge clk_i or posedge async_rst_i) begin
    if (async_rst_i) begin
      state_q <= SARB_IDLE;
      cnt_q   <= '0;
      last_q  <= OWNER_IRS;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    if (accept && !rsp_any) begin
      cnt_d = cnt_q + CNT_ONE;
    end else if (!accept && rsp_any && cnt_q != '0) begin
      cnt_d = cnt_q - CNT_ONE;
    end
    case (state_q)
      SARB_IDLE: begin
        cnt_d = '0;
        if (ips_sarb.cyc && (!irs_sarb.cyc || last_q == OWNER_IRS)) begin
          state_d = SARB_GNT_IPS;
        end else if (irs_sarb.cyc) begin
          state_d = SARB_GNT_IRS;
        end
      end
      SARB_GNT_IPS: begin
        if (!ips_sarb.cyc) begin
          cnt_d   = '0;
          last_d  = OWNER_IPS;
          state_d = irs_sarb.cyc ? SARB_GNT_IRS : SARB_IDLE;
        end
      end
      SARB_GNT_IRS: begin
        if (!irs_sarb.cyc) begin
          cnt_d   = '0;
          last_d  = OWNER_IRS;
          state_d = ips_sarb.cyc ? SARB_GNT_IPS : SARB_IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = SARB_IDLE;
      end
    endcase
  end

  // Output routing: owner's request to the target, target's responses to the owner.
  always_comb begin
    sarb.cyc       = 1'b0;
    sarb.stb       = 1'b0;
    sarb.we        = 1'b0;
    sarb.adr       = '0;
    sarb.wdat      = '0;
    ips_sarb.stall = 1'b1;
    irs_sarb.stall = 1'b1;
    ips_sarb.rdat  = sarb.rdat;
    irs_sarb.rdat  = sarb.rdat;
    ips_rsp        = rsp_route(rsp, state_q == SARB_GNT_IPS);
    irs_rsp        = rsp_route(rsp, state_q == SARB_GNT_IRS);
    case (state_q)
      SARB_GNT_IPS: begin
        sarb.cyc       = ips_sarb.cyc;
        sarb.stb       = ips_sarb.cyc & ips_sarb.stb & ~cap;
        sarb.we        = ips_sarb.we;
        sarb.adr       = ips_sarb.adr;
        sarb.wdat      = ips_sarb.wdat;
        ips_sarb.stall = sarb.stall | cap;
        irs_sarb.rdat  = '0;
      end
      SARB_GNT_IRS: begin
        sarb.cyc       = irs_sarb.cyc;
        sarb.stb       = irs_sarb.cyc & irs_sarb.stb & ~cap;
        sarb.we        = irs_sarb.we;
        sarb.adr       = irs_sarb.adr;
        sarb.wdat      = irs_sarb.wdat;
        irs_sarb.stall = sarb.stall | cap;
        ips_sarb.rdat  = '0;
      end
      default: ;
    endcase
    ips_sarb.ack = ips_rsp.ack;
    ips_sarb.err = ips_rsp.err;
    ips_sarb.rty = ips_rsp.rty;
    irs_sarb.ack = irs_rsp.ack;
    irs_sarb.err = irs_rsp.err;
    irs_sarb.rty = irs_rsp.rty;
  end

  assign prb_sarb_state_o = state_q;
  assign prb_sarb_cnt_o   = cnt_q;

endmodule
